// File: rtl/delay_timer_pkg.sv
// Shared constants for the serial-programmed delay timer: state encodings
// and the default prescaler length.
package delay_timer_pkg;

  localparam int CYCLES_PER_UNIT_DEF = 1000;

  typedef logic [3:0] state_t;

  // SEARCH sub-states, SHIFT phases, then the timing states.
  localparam logic [3:0] ST_S0       = 4'd0;
  localparam logic [3:0] ST_S1       = 4'd1;
  localparam logic [3:0] ST_S11      = 4'd2;
  localparam logic [3:0] ST_S110     = 4'd3;
  localparam logic [3:0] ST_B0       = 4'd4;
  localparam logic [3:0] ST_B1       = 4'd5;
  localparam logic [3:0] ST_B2       = 4'd6;
  localparam logic [3:0] ST_B3       = 4'd7;
  localparam logic [3:0] ST_COUNT    = 4'd8;
  localparam logic [3:0] ST_WAIT_ACK = 4'd9;

endpackage

// File: rtl/unit_prescaler.sv
// Free-running cycle prescaler: counts 0..CYCLES_PER_UNIT-1 while enabled
// and flags the last cycle of each unit.
module unit_prescaler
  import delay_timer_pkg::*;
#(
  parameter int CYCLES_PER_UNIT = CYCLES_PER_UNIT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic clr_i,
  output logic tc_o
);

  localparam int W = (CYCLES_PER_UNIT > 1) ? $clog2(CYCLES_PER_UNIT) : 1;
  localparam logic [W-1:0] LAST = W'(CYCLES_PER_UNIT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tc_o = en_i && (cnt_q == LAST);

  // The terminal count folds back to zero so the counter never passes LAST.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tc_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/delay_timer.sv
// Delay timer: finds 1101 on the serial input, loads a 4-bit delay MSB first,
// runs for (delay+1) units, then holds done until acknowledged.
module delay_timer
  import delay_timer_pkg::*;
#(
  parameter int CYCLES_PER_UNIT = CYCLES_PER_UNIT_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       data,
  input  logic       ack,
  output logic [3:0] count,
  output logic       counting,
  output logic       done,
  output logic [3:0] dbg_state_o
);

  state_t     state_q, state_d;
  logic [3:0] delay_q, delay_d;
  logic       unit_tc;

  unit_prescaler #(
    .CYCLES_PER_UNIT(CYCLES_PER_UNIT)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en_i  (state_q == ST_COUNT),
    .clr_i (state_q == ST_B3),
    .tc_o  (unit_tc)
  );

  always_comb begin
    state_d = state_q;
    delay_d = delay_q;
    case (state_q)
      ST_S0:   state_d = data ? ST_S1   : ST_S0;
      ST_S1:   state_d = data ? ST_S11  : ST_S0;
      ST_S11:  state_d = data ? ST_S11  : ST_S110;
      ST_S110: state_d = data ? ST_B0   : ST_S0;
      ST_B0: begin
        delay_d = {delay_q[2:0], data};
        state_d = ST_B1;
      end
      ST_B1: begin
        delay_d = {delay_q[2:0], data};
        state_d = ST_B2;
      end
      ST_B2: begin
        delay_d = {delay_q[2:0], data};
        state_d = ST_B3;
      end
      ST_B3: begin
        delay_d = {delay_q[2:0], data};
        state_d = ST_COUNT;
      end
      // The delay register doubles as the down-counter of remaining units.
      ST_COUNT: begin
        if (unit_tc) begin
          if (delay_q != 4'd0) begin
            delay_d = delay_q - 4'd1;
          end else begin
            state_d = ST_WAIT_ACK;
          end
        end
      end
      ST_WAIT_ACK: begin
        if (ack) begin
          state_d = ST_S0;
        end
      end
      default: begin
        state_d = ST_S0;
        delay_d = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_S0;
      delay_q <= 4'd0;
    end else begin
      state_q <= state_d;
      delay_q <= delay_d;
    end
  end

  assign counting    = (state_q == ST_COUNT);
  assign done        = (state_q == ST_WAIT_ACK);
  assign count       = counting ? delay_q : 4'd0;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_delay_timer.sv
// Bench for delay_timer: serial programming, unit timing, ack handling and
// asynchronous reset, on a 1000-cycle-unit instance and a 2-cycle-unit one.
module tb_delay_timer;

  logic       clk;
  logic       reset;
  logic       data, ack, data2, ack2;
  logic [3:0] count, count2, dbg_state, dbg_state2;
  logic       counting, counting2, done, done2;

  logic       sel;
  logic [3:0] m_count;
  logic       m_counting, m_done;

  logic [3:0] exp_q[$];
  int         len_q[$];
  int         n_checks = 0;
  int         n_err = 0;

  delay_timer #(.CYCLES_PER_UNIT(1000)) dut (
    .clk(clk), .reset(reset), .data(data), .ack(ack), .count(count),
    .counting(counting), .done(done), .dbg_state_o(dbg_state)
  );

  delay_timer #(.CYCLES_PER_UNIT(2)) dut2 (
    .clk(clk), .reset(reset), .data(data2), .ack(ack2), .count(count2),
    .counting(counting2), .done(done2), .dbg_state_o(dbg_state2)
  );

  assign m_count    = sel ? count2    : count;
  assign m_counting = sel ? counting2 : counting;
  assign m_done     = sel ? done2     : done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      if (sel) data2 = bits[i];
      else     data  = bits[i];
      tick();
    end
    data  = 1'b0;
    data2 = 1'b0;
  endtask

  // Push the expected count per unit and the expected run length, then program.
  task automatic start_run(input logic [15:0] pat, input int n, input logic [3:0] d, input int cpu);
    for (int u = int'(d); u >= 0; u--) exp_q.push_back(4'(u));
    len_q.push_back((int'(d) + 1) * cpu);
    send_bits(pat, n);
    send_bits({12'd0, d}, 4);
  endtask

  task automatic measure(input int cpu);
    int         k;
    int         exp_len;
    logic [3:0] cur;
    k = 0;
    cur = 4'bx;
    exp_len = (len_q.size() != 0) ? len_q.pop_front() : -1;
    while (m_counting && k < 20000) begin
      if (k % cpu == 0) begin
        cur = (exp_q.size() != 0) ? exp_q.pop_front() : 4'bx;
        chk("count_unit_start", 32'(m_count), 32'(cur));
      end
      if (k % cpu == cpu - 1) chk("count_unit_end", 32'(m_count), 32'(cur));
      tick();
      k++;
    end
    chk("run_length", k, exp_len);
    chk("done_after_run", 32'(m_done), 1);
    chk("count_after_run", 32'(m_count), 0);
    chk("units_consumed", exp_q.size(), 0);
  endtask

  task automatic do_ack();
    if (sel) ack2 = 1'b1;
    else     ack  = 1'b1;
    tick();
    ack  = 1'b0;
    ack2 = 1'b0;
    chk("done_cleared", 32'(m_done), 0);
    chk("idle_after_ack", 32'(m_counting), 0);
  endtask

  task automatic expect_idle(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      if (m_counting || m_done) seen = 1;
      tick();
    end
    chk(tag, seen, 0);
  endtask

  initial begin
    sel = 1'b0; data = 1'b0; data2 = 1'b0; ack = 1'b0; ack2 = 1'b0;
    reset = 1'b1;
    tick(); tick();
    chk("reset_counting", 32'(counting), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_count", 32'(count), 0);
    reset = 1'b0;
    tick();

    // delay 5: six units of 1000 cycles
    start_run(16'b1101, 4, 4'd5, 1000);
    measure(1000);
    do_ack();

    // delay 0: a single unit
    start_run(16'b1101, 4, 4'd0, 1000);
    measure(1000);
    do_ack();

    // overlapping pattern 11101, delay 15
    start_run(16'b11101, 5, 4'd15, 1000);
    measure(1000);
    do_ack();

    // ack held through COUNT is ignored; done holds until a real ack
    ack = 1'b1;
    start_run(16'b1101, 4, 4'd0, 1000);
    measure(1000);
    ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("done_held", 32'(done), 1);
    end
    do_ack();
    send_bits(16'b101, 3);
    expect_idle("no_run_after_101", 20);

    // asynchronous reset in the middle of COUNT
    start_run(16'b1101, 4, 4'd5, 1000);
    for (int i = 0; i < 2500; i++) tick();
    chk("counting_before_reset", 32'(counting), 1);
    #2 reset = 1'b1;
    #1;
    chk("async_counting", 32'(counting), 0);
    chk("async_done", 32'(done), 0);
    chk("async_count", 32'(count), 0);
    #2 reset = 1'b0;
    exp_q.delete();
    len_q.delete();
    tick();
    send_bits(16'b0101, 4);
    expect_idle("no_run_without_pattern", 20);
    start_run(16'b1101, 4, 4'd0, 1000);
    measure(1000);
    do_ack();

    // short-unit instance: delay 3 at 2 cycles per unit
    sel = 1'b1;
    start_run(16'b1101, 4, 4'd3, 2);
    measure(2);
    do_ack();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/delay_timer.md
DELAY_TIMER -- requirements
Module: delay_timer

Interface
REQ-001 SHALL have parameter: CYCLES_PER_UNIT, 1000, clock cycles per count unit (>=2).
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on posedge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: data  input  1  serial stream carrying the start pattern, then a 4-bit delay, MSB first.
REQ-005 SHALL have port: ack  input  1  user acknowledge of timer expiry.
REQ-006 SHALL have port: count  output  4  remaining whole units while counting.
REQ-007 SHALL have port: counting  output  1  high while the timer is running.
REQ-008 SHALL have port: done  output  1  high from timer expiry until acknowledged.

Function
REQ-009 SHALL implement states SEARCH (sub-states S0, S1, S11, S110), SHIFT (4 phases B0..B3), COUNT, and WAIT_ACK.
REQ-010 SHALL sample data on every posedge in SEARCH and detect pattern 1101 with overlap (e.g. 1,1,1,0,1 detects; S11 on 1 stays S11; S110 on 0 returns S0).
REQ-011 SHALL enter SHIFT on the edge after the pattern's final 1 is sampled.
REQ-012 SHALL shift data into a 4-bit delay register on exactly 4 consecutive edges in SHIFT, first bit to bit 3.
REQ-013 SHALL enter COUNT on the edge that samples the 4th delay bit, clear the prescaler to 0 there, and assert counting=1 from the next cycle.
REQ-014 SHALL drive count = delay register value in COUNT; the prescaler increments each cycle from 0 to CYCLES_PER_UNIT-1.
REQ-015 SHALL, when prescaler = CYCLES_PER_UNIT-1 and count != 0, decrement count and clear the prescaler on that edge.
REQ-016 SHALL, when prescaler = CYCLES_PER_UNIT-1 and count = 0, enter WAIT_ACK on that edge; counting is high for exactly (delay+1)*CYCLES_PER_UNIT cycles.
REQ-017 SHALL assert done=1 and counting=0 in WAIT_ACK; count holds 0.
REQ-018 SHALL, when ack=1 is sampled in WAIT_ACK, return to SEARCH/S0 (no pattern history retained); done falls the next cycle.
REQ-019 SHALL ignore ack outside WAIT_ACK and ignore data in SHIFT-independent states COUNT and WAIT_ACK.
REQ-020 SHALL derive counting and done combinationally from the state register only (Moore outputs, glitch-free to user).
REQ-021 SHALL size the prescaler at $clog2(CYCLES_PER_UNIT) bits with no wrap beyond CYCLES_PER_UNIT-1.

Reset
REQ-022 SHALL, on reset=1 at any time (including mid-SHIFT or mid-COUNT), immediately force SEARCH/S0, delay register 0, prescaler 0, count=0, counting=0, done=0.
REQ-023 SHALL require a fresh 1101 pattern after reset deassertion before any new timing run.

Structure
REQ-024 SHALL place the state enumeration and the CYCLES_PER_UNIT default constant in a shared package delay_timer_pkg.
REQ-025 SHALL implement the prescaler as sub-module unit_prescaler (enable, clear, terminal-count output).
REQ-026 SHALL keep the delay register/down-counter and FSM in delay_timer itself.

Verification
REQ-027 SHALL cover: data 1,1,0,1 then 0,1,0,1 (delay 5), CYCLES_PER_UNIT=1000 -> counting high 6000 cycles, count 5,4,3,2,1,0 each for 1000 cycles, then done=1.
REQ-028 SHALL cover: pattern then 0,0,0,0 -> counting high exactly 1000 cycles, count=0 throughout, then done=1.
REQ-029 SHALL cover: data 1,1,1,0,1 then 1,1,1,1 -> overlap detected, delay 15, counting high 16000 cycles.
REQ-030 SHALL cover: ack=1 held during COUNT -> ignored; done stays 1 until ack pulse in WAIT_ACK; afterwards data 1,0,1 alone does not start a run.
REQ-031 SHALL cover: reset asserted asynchronously 2500 cycles into COUNT -> counting, done, count all 0 before the next clock edge; no run until new 1101.
REQ-032 SHALL cover: CYCLES_PER_UNIT=2, delay 3 -> counting high exactly 8 cycles.
